// File: rtl/regfile_wb_pkg.sv
// rtl/regfile_wb_pkg.sv - shared widths and constants for the write-back register file
package regfile_wb_pkg;

    localparam int RegBus     = 32;
    localparam int RegAddrBus = 5;
    localparam int RegNum     = 32;

    localparam logic [RegBus-1:0]     ZeroWord   = '0;
    localparam logic [RegAddrBus-1:0] NOPRegAddr = '0;

    localparam logic WriteEnable  = 1'b1;
    localparam logic WriteDisable = 1'b0;
    localparam logic ReadEnable   = 1'b1;
    localparam logic ReadDisable  = 1'b0;

    // rst is active-low
    localparam logic RstEnable = 1'b0;

endpackage

// File: rtl/hilo_reg.sv
// rtl/hilo_reg.sv - HI/LO register pair with same-cycle write-through bypass
module hilo_reg
    import regfile_wb_pkg::*;
#(
    parameter int DATA_W = RegBus
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              whilo,
    input  logic [DATA_W-1:0] hi_i,
    input  logic [DATA_W-1:0] lo_i,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (whilo == WriteEnable) begin
            hi_q <= hi_i;
            lo_q <= lo_i;
        end
    end

    always_comb begin
        hi_o = '0;
        lo_o = '0;
        if (rst != RstEnable) begin
            hi_o = (whilo == WriteEnable) ? hi_i : hi_q;
            lo_o = (whilo == WriteEnable) ? lo_i : lo_q;
        end
    end

endmodule

// File: rtl/regfile_wb.sv
// rtl/regfile_wb.sv - 32-entry GPR file with two bypassed read ports plus HI/LO pair
module regfile_wb
    import regfile_wb_pkg::*;
#(
    parameter int DATA_W   = RegBus,
    parameter int ADDR_W   = RegAddrBus,
    parameter int NUM_REGS = RegNum
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    input  logic              whilo,
    input  logic [DATA_W-1:0] hi_i,
    input  logic [DATA_W-1:0] lo_i,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(NOPRegAddr);

    logic [DATA_W-1:0] regs [NUM_REGS];

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we == WriteEnable && waddr != ZERO_ADDR) begin
            regs[waddr] <= wdata;
        end
    end

    // r0 is hardwired to zero, so the bypass never forwards a write to it
    function automatic logic [DATA_W-1:0] read_port(input logic re, input logic [ADDR_W-1:0] raddr);
        logic [DATA_W-1:0] val;
        val = '0;
        if (rst == RstEnable || re != ReadEnable || raddr == ZERO_ADDR) begin
            val = '0;
        end else if (we == WriteEnable && waddr == raddr) begin
            val = wdata;
        end else begin
            val = regs[raddr];
        end
        return val;
    endfunction

    always_comb begin
        rdata1 = read_port(re1, raddr1);
        rdata2 = read_port(re2, raddr2);
    end

    hilo_reg #(
        .DATA_W(DATA_W)
    ) u_hilo (
        .clk  (clk),
        .rst  (rst),
        .whilo(whilo),
        .hi_i (hi_i),
        .lo_i (lo_i),
        .hi_o (hi_o),
        .lo_o (lo_o)
    );

endmodule

// File: tb/tb_regfile_wb.sv
// tb/tb_regfile_wb.sv - scoreboard bench for regfile_wb
module tb_regfile_wb;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic        whilo;
    logic [31:0] hi_i;
    logic [31:0] lo_i;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];

    logic [31:0] model_regs [32];
    logic [31:0] model_hi;
    logic [31:0] model_lo;

    always #5 clk = ~clk;

    regfile_wb dut (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .re1   (re1),
        .raddr1(raddr1),
        .rdata1(rdata1),
        .re2   (re2),
        .raddr2(raddr2),
        .rdata2(rdata2),
        .whilo (whilo),
        .hi_i  (hi_i),
        .lo_i  (lo_i),
        .hi_o  (hi_o),
        .lo_o  (lo_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_read(input logic r, input logic re, input logic [4:0] ra,
                                             input logic w, input logic [4:0] wa, input logic [31:0] wd);
        if (!r || !re || ra == 5'd0) return 32'h0;
        if (w && wa == ra) return wd;
        return model_regs[ra];
    endfunction

    task automatic pop_check(input logic [31:0] obs);
        exp_t e;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check(e.tag, obs, e.exp);
        end
    endtask

    // Drives one cycle at the falling edge, checks the combinational outputs, then
    // advances the model at the rising edge.
    task automatic cycle(input string name, input logic r,
                         input logic w, input logic [4:0] wa, input logic [31:0] wd,
                         input logic e1, input logic [4:0] a1,
                         input logic e2, input logic [4:0] a2,
                         input logic wh, input logic [31:0] h, input logic [31:0] l);
        exp_t e;
        @(negedge clk);
        rst = r; we = w; waddr = wa; wdata = wd;
        re1 = e1; raddr1 = a1; re2 = e2; raddr2 = a2;
        whilo = wh; hi_i = h; lo_i = l;
        e.tag = {name, "/rdata1"}; e.exp = exp_read(r, e1, a1, w, wa, wd); sb.push_back(e);
        e.tag = {name, "/rdata2"}; e.exp = exp_read(r, e2, a2, w, wa, wd); sb.push_back(e);
        e.tag = {name, "/hi_o"};   e.exp = !r ? 32'h0 : (wh ? h : model_hi); sb.push_back(e);
        e.tag = {name, "/lo_o"};   e.exp = !r ? 32'h0 : (wh ? l : model_lo); sb.push_back(e);
        #1;
        pop_check(rdata1);
        pop_check(rdata2);
        pop_check(hi_o);
        pop_check(lo_o);
        @(posedge clk);
        if (!r) begin
            for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;
            model_hi = 32'h0;
            model_lo = 32'h0;
        end else begin
            if (w && wa != 5'd0) model_regs[wa] = wd;
            if (wh) begin
                model_hi = h;
                model_lo = l;
            end
        end
    endtask

    task automatic idle_read(input string name, input logic [4:0] a1, input logic [4:0] a2);
        cycle(name, 1'b1, 1'b0, 5'd0, 32'h0, 1'b1, a1, 1'b1, a2, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        rst = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
        re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0;
        whilo = 1'b0; hi_i = '0; lo_i = '0;
        for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;
        model_hi = 32'h0;
        model_lo = 32'h0;

        // reset with random traffic
        for (int i = 0; i < 6; i++) begin
            cycle("rst_traffic", 1'b0, 1'b1, 5'($urandom_range(1, 31)), $urandom,
                  1'b1, 5'($urandom), 1'b1, 5'($urandom), 1'b1, $urandom, $urandom);
        end
        for (int i = 1; i < 32; i++) begin
            idle_read("post_rst", 5'(i), 5'(32 - i));
        end

        // basic write then read, port 2 disabled
        cycle("wr5", 1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0);
        cycle("rd5", 1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b0, 5'd5, 1'b0, 32'h0, 32'h0);

        // same-cycle bypass on both ports, then stored value
        cycle("byp7", 1'b1, 1'b1, 5'd7, 32'h12345678, 1'b1, 5'd7, 1'b1, 5'd7, 1'b0, 32'h0, 32'h0);
        idle_read("stored7", 5'd7, 5'd7);
        cycle("byp7_over", 1'b1, 1'b1, 5'd7, 32'hCAFEF00D, 1'b1, 5'd7, 1'b1, 5'd5, 1'b0, 32'h0, 32'h0);

        // r0 stays zero, including under same-cycle write
        cycle("wr0", 1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 32'h0, 32'h0);
        idle_read("rd0", 5'd0, 5'd0);
        cycle("wr31", 1'b1, 1'b1, 5'd31, 32'h80000001, 1'b1, 5'd31, 1'b1, 5'd30, 1'b0, 32'h0, 32'h0);

        // HI/LO write, hold, and a second write alongside a GPR write
        cycle("hilo_wr", 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 32'hAAAA0000, 32'h0000BBBB);
        cycle("hilo_hold", 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 32'h55555555, 32'h66666666);
        cycle("hilo_wr2", 1'b1, 1'b1, 5'd9, 32'h00000999, 1'b1, 5'd9, 1'b0, 5'd0, 1'b1, 32'h01234567, 32'h89ABCDEF);
        idle_read("hilo_hold2", 5'd9, 5'd5);

        // random mixed traffic against the model
        for (int i = 0; i < 60; i++) begin
            cycle("rand", 1'b1, 1'($urandom), 5'($urandom), $urandom,
                  1'($urandom), 5'($urandom), 1'($urandom), 5'($urandom),
                  1'($urandom), $urandom, $urandom);
        end

        // reset mid-operation: asserted between edges, write during reset discarded
        cycle("wr3_hi", 1'b1, 1'b1, 5'd3, 32'h00000011, 1'b1, 5'd3, 1'b0, 5'd0, 1'b1, 32'h00000022, 32'h00000033);
        idle_read("pre_rst3", 5'd3, 5'd3);
        cycle("mid_rst", 1'b0, 1'b1, 5'd3, 32'h00000099, 1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 32'h00000077, 32'h00000088);
        idle_read("post_rst3", 5'd3, 5'd3);
        idle_read("post_rst_5_7", 5'd5, 5'd7);

        if (sb.size() != 0) check("scoreboard_leftover", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_wb.md
Name: regfile_wb

Overview:
- Write-back destination for the integer pipeline. Consumes the register-write triple (dest addr, write enable, data) and the HI/LO write triple (whilo, hi, lo) from the MEM/WB stage.
- Contents: a 32-entry general-purpose register file and the HI/LO pair.
- Read side: two read ports for the ID stage, plus HI/LO outputs for EX. All read paths have write-through bypass, so a value written this cycle is visible to a same-cycle read.

Parameters:
- DATA_W, 32, width of every register, HI and LO.
- ADDR_W, 5, register address width.
- NUM_REGS, 32, number of GPRs; must equal 2**ADDR_W.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- we  in  1  GPR write enable from WB.
- waddr  in  ADDR_W  GPR write address.
- wdata  in  DATA_W  GPR write data.
- re1  in  1  read enable, port 1.
- raddr1  in  ADDR_W  read address, port 1.
- rdata1  out  DATA_W  read data, port 1.
- re2  in  1  read enable, port 2.
- raddr2  in  ADDR_W  read address, port 2.
- rdata2  out  DATA_W  read data, port 2.
- whilo  in  1  HI/LO write enable from WB.
- hi_i  in  DATA_W  HI write data.
- lo_i  in  DATA_W  LO write data.
- hi_o  out  DATA_W  current HI (bypassed).
- lo_o  out  DATA_W  current LO (bypassed).

Behaviour:

Reset:
- rst low clears all NUM_REGS entries, HI and LO to zero immediately, without waiting for clk.
- While rst is low, rdata1, rdata2, hi_o and lo_o are forced to zero.
- A write presented on the edge during which rst is low is discarded.

GPR write:
- At a rising edge with rst high and we=1, entry waddr is loaded with wdata.
- Writes to address 0 are ignored; r0 always reads zero.
- One write per cycle; write latency is one edge.

GPR read (combinational, zero latency), per port n, in priority order:
1. rst low -> 0.
2. ren=0 -> 0.
3. raddrn=0 -> 0.
4. we=1 and waddr=raddrn -> wdata (bypass).
5. otherwise -> stored entry raddrn.

GPR port independence:
- Both ports may read the same address in the same cycle, including the write address; both see identical data.

HI/LO:
- At a rising edge with rst high and whilo=1, HI<=hi_i and LO<=lo_i together. There is no partial write.
- hi_o = whilo ? hi_i : HI, and lo_o = whilo ? lo_i : LO, with zero latency.

Other rules:
- No arithmetic; data is stored and returned bit-exact.
- GPR and HI/LO writes in the same cycle are independent and both take effect.
- Reset released between edges: the first rising edge with rst high performs normal writes.

Decomposition:
- Shared defines/package holds:
  - widths: RegBus (DATA_W), RegAddrBus (ADDR_W), RegNum (NUM_REGS).
  - constants: ZeroWord, NOPRegAddr, WriteEnable/WriteDisable, ReadEnable/ReadDisable.
  - reset level constant for active-low rst.
- One sub-module is natural: hilo_reg. It holds the HI/LO pair, the whilo write and the bypass mux, and is instantiated once.
- GPR array, write logic and the two read muxes stay in regfile_wb.

Test Plan:
1. rst low with random traffic on all inputs -> rdata1/2, hi_o, lo_o = 0. Release rst, then read r1..r31 -> all 0.
2. we=1, waddr=5, wdata=0xDEADBEEF, at one edge; next cycle re1=1, raddr1=5 -> rdata1=0xDEADBEEF. Same cycle re2=0 -> rdata2=0.
3. Same-cycle bypass: we=1, waddr=7, wdata=0x12345678, with raddr1=raddr2=7, re1=re2=1 -> both ports show 0x12345678 before the edge, and stored value afterwards.
4. we=1, waddr=0, wdata=0xFFFFFFFF, edge; then read r0 on both ports, also with same-cycle write to r0 -> always 0.
5. HI/LO: whilo=1, hi_i=0xAAAA0000, lo_i=0x0000BBBB -> hi_o/lo_o show new values combinationally, and hold them after the edge with whilo=0. A second write with whilo=1 updates both together.
6. Reset mid-operation: write r3=0x11 and HI=0x22; assert rst asynchronously between edges -> outputs 0 immediately. After release, r3 and HI read 0. A write on the edge while rst is low is not retained.
